fetch_stall_ctrl: RTL

- Centralised sequencer for the Fetch stage.
- Arbitrates the branch-stall, dependency-stall and GPU-stall inputs and the branch-resolve redirect.
- Tells Fetch each cycle whether to advance the PC, hold, inject a NOP or redirect, and whether its output latch is valid.
- Replaces the ad-hoc bubble logic inside Fetch with an explicit state machine and a saturating stall counter.

---
 rtl/fetch_stall_ctrl_pkg.sv | 21 ++
 rtl/fetch_stall_ctrl_sat_counter.sv | 27 ++
 rtl/fetch_stall_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared encodings for the Fetch stall sequencer.
package fetch_stall_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_DEP_HOLD  = 3'd1,
      ST_BR_WAIT   = 3'd2,
      ST_BR_BUBBLE = 3'd3,
      ST_GPU_HOLD  = 3'd4
   } fsc_state_e;

   // Fetch IR source select
   localparam logic [1:0] IRSEL_IMEM = 2'd0;  // IMEM[I_PC]
   localparam logic [1:0] IRSEL_HOLD = 2'd1;  // keep current IR
   localparam logic [1:0] IRSEL_NOP  = 2'd2;  // inject NOP_IR
   localparam logic [1:0] IRSEL_BRT  = 2'd3;  // IMEM[I_BranchPC]

   localparam logic [31:0] NOP_IR = 32'hFF000000;
   localparam int          PC_INC = 4;

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and async active-low clear, negedge clocked.
module fsc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Increment while enabled, stick at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   // Counter register
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stage sequencer: arbitrates redirect / GPU / dependency / branch stalls
// and tells Fetch whether to advance, hold, inject a NOP or redirect.
module fetch_stall_ctrl
   import fetch_stall_ctrl_pkg::*;
#(
   parameter int PC_WIDTH   = 16,
   parameter int BR_BUBBLES = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 I_CLOCK,
   input  logic                 I_LOCK,
   input  logic                 I_BranchStallSignal,
   input  logic                 I_DepStallSignal,
   input  logic                 I_GPUStallSignal,
   input  logic                 I_BranchAddrSelect,
   input  logic [PC_WIDTH-1:0]  I_BranchPC,
   input  logic [PC_WIDTH-1:0]  I_PC,
   output logic [PC_WIDTH-1:0]  O_NextPC,
   output logic                 O_PCWrite,
   output logic [1:0]           O_IRSel,
   output logic                 O_FE_Valid,
   output logic [2:0]           O_State,
   output logic [CNT_WIDTH-1:0] O_StallCycles
);

   localparam logic [2:0] BUB_LAST = 3'(BR_BUBBLES - 1);

   fsc_state_e state_q, state_d, saved_q, saved_d, eff_st, b_next;
   logic [2:0] bcnt_q, bcnt_d, b_cnt;
   logic       saved_vld_q, saved_vld_d;
   logic       b_pcw, b_vld, pcw, vld;
   logic [1:0] b_irsel, irsel;
   logic [PC_WIDTH-1:0] npc;

   // Next state and Mealy outputs: base behaviour of the effective state,
   // then GPU freeze and redirect layered on top by priority
   always_comb begin
      // GPU_HOLD acts as the state it interrupted; illegal codes act as RUN
      eff_st = (state_q == ST_GPU_HOLD) ? saved_q : state_q;
      if (3'(eff_st) >= 3'(ST_GPU_HOLD)) eff_st = ST_RUN;

      b_pcw   = 1'b0;
      b_irsel = IRSEL_NOP;
      b_vld   = 1'b0;
      b_next  = eff_st;
      b_cnt   = bcnt_q;
      case (eff_st)
         ST_BR_WAIT: begin
            if (!I_BranchStallSignal) begin
               b_next = ST_BR_BUBBLE;
               b_cnt  = '0;
            end
         end
         ST_BR_BUBBLE: begin
            if (I_BranchStallSignal) begin
               b_next = ST_BR_WAIT;
               b_cnt  = '0;
            end else if (bcnt_q == BUB_LAST) begin
               b_next = ST_RUN;
               b_cnt  = '0;
            end else begin
               b_cnt  = bcnt_q + 3'd1;
            end
         end
         default: begin  // RUN and DEP_HOLD share the same rules
            if (I_DepStallSignal) begin
               b_irsel = IRSEL_HOLD;
               b_vld   = 1'b1;
               b_next  = ST_DEP_HOLD;
            end else if (I_BranchStallSignal) begin
               b_irsel = IRSEL_HOLD;
               b_next  = ST_BR_WAIT;
            end else begin
               b_pcw   = 1'b1;
               b_irsel = IRSEL_IMEM;
               b_vld   = 1'b1;
               b_next  = ST_RUN;
            end
         end
      endcase

      state_d     = b_next;
      bcnt_d      = b_cnt;
      saved_d     = saved_q;
      saved_vld_d = saved_vld_q;
      pcw         = b_pcw;
      npc         = I_PC + PC_WIDTH'(PC_INC);
      irsel       = b_irsel;
      vld         = b_vld;

      if (I_BranchAddrSelect) begin
         pcw     = 1'b1;
         npc     = I_BranchPC;
         irsel   = IRSEL_BRT;
         vld     = 1'b1;
         state_d = ST_RUN;
         bcnt_d  = '0;
      end else if (I_GPUStallSignal) begin
         // Bubble count frozen from the entry cycle so the remaining NOPs survive
         pcw     = 1'b0;
         irsel   = IRSEL_HOLD;
         bcnt_d  = bcnt_q;
         state_d = ST_GPU_HOLD;
         if (state_q == ST_GPU_HOLD) begin
            vld = saved_vld_q;
         end else begin
            saved_d     = eff_st;
            saved_vld_d = b_vld;
         end
      end
   end

   // State, bubble counter and GPU save registers
   always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
      if (!I_LOCK) begin
         state_q     <= ST_RUN;
         bcnt_q      <= '0;
         saved_q     <= ST_RUN;
         saved_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         saved_q     <= saved_d;
         saved_vld_q <= saved_vld_d;
      end
   end

   // Outputs are forced quiet while the lock is low
   assign O_PCWrite  = I_LOCK & pcw;
   assign O_NextPC   = I_LOCK ? npc : '0;
   assign O_IRSel    = I_LOCK ? irsel : IRSEL_NOP;
   assign O_FE_Valid = I_LOCK & vld;
   assign O_State    = state_q;

   fsc_sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
      .clk_i  (I_CLOCK),
      .rst_ni (I_LOCK),
      .en_i   (I_LOCK & ~pcw),
      .cnt_o  (O_StallCycles)
   );

endmodule
